// File: rtl/fibonacci_checker.sv
// rtl/fibonacci_checker.sv - checks a sample stream against F(n+1) = F(n) + F(n-1) mod 2^FibBits
// Optional: FIB_STRICT_START_EN requires the stream to start with the extended series 0, 1.
module fibonacci_checker #(
  parameter int FibBits = 10,
  parameter int CntBits = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clr,
  input  logic               valid,
  input  logic [FibBits-1:0] din,
  output logic [FibBits-1:0] expected,
  output logic               locked,
  output logic               err_pulse,
  output logic               err_sticky,
  output logic [CntBits-1:0] match_cnt,
  output logic [CntBits-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, SEED, CHECK} state_t;

  state_t             state_q, state_d;
  logic [FibBits-1:0] a_q, a_d, b_q, b_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic               err_sticky_q, err_sticky_d;
  logic [CntBits-1:0] match_cnt_q, match_cnt_d;
  logic [CntBits-1:0] err_cnt_q, err_cnt_d;
  logic               hit;

  assign expected   = a_q + b_q;
  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign match_cnt  = match_cnt_q;
  assign err_cnt    = err_cnt_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      match_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      match_cnt_q  <= match_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    locked_d     = locked_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    match_cnt_d  = match_cnt_q;
    err_cnt_d    = err_cnt_q;
    hit          = 1'b1;
    if (clr) begin
      state_d      = IDLE;
      a_d          = '0;
      b_d          = '0;
      locked_d     = 1'b0;
      err_sticky_d = 1'b0;
      match_cnt_d  = '0;
      err_cnt_d    = '0;
    end else if (valid) begin
      // hit: the sample is what the current state requires
      case (state_q)
`ifdef FIB_STRICT_START_EN
        IDLE:    hit = (din == '0);
        SEED:    hit = (din == FibBits'(1));
`endif
        CHECK:   hit = (din == expected);
        default: hit = 1'b1;
      endcase
      if (hit) begin
        case (state_q)
          IDLE: begin
            b_d     = din;
            state_d = SEED;
          end
          SEED: begin
            a_d     = b_q;
            b_d     = din;
            state_d = CHECK;
          end
          default: begin
            a_d      = b_q;
            b_d      = din;
            locked_d = 1'b1;
            if (match_cnt_q != '1) match_cnt_d = match_cnt_q + CntBits'(1);
          end
        endcase
      end else begin
        err_pulse_d  = 1'b1;
        err_sticky_d = 1'b1;
        locked_d     = 1'b0;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CntBits'(1);
`ifdef FIB_STRICT_START_EN
        // only a zero can restart the 0, 1 prefix
        if (din == '0) begin
          b_d     = '0;
          state_d = SEED;
        end else begin
          state_d = IDLE;
        end
`else
        b_d     = din;
        state_d = SEED;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_checker.sv
// tb/tb_fibonacci_checker.sv - randomized and directed bench for fibonacci_checker (default build)
module tb_fibonacci_checker;

  logic       clk = 1'b0;
  logic       nrst;
  logic       clr;
  logic       valid;
  logic [9:0] din;
  logic [9:0] expected;
  logic       locked;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] match_cnt;
  logic [7:0] err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference: the current run of accepted samples and the last two of them
  int run_len;
  int last1, last2;
  int m_match, m_err;
  bit m_locked, m_pulse, m_sticky;

  always #5 clk = ~clk;

  fibonacci_checker #(.FibBits(10), .CntBits(8)) dut (
    .clk(clk), .nrst(nrst), .clr(clr), .valid(valid), .din(din),
    .expected(expected), .locked(locked), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .match_cnt(match_cnt), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    run_len = 0; last1 = 0; last2 = 0;
    m_match = 0; m_err = 0;
    m_locked = 0; m_pulse = 0; m_sticky = 0;
  endtask

  task automatic model_sample(input int v);
    int pred;
    m_pulse = 0;
    if (run_len >= 2) begin
      pred = (last1 + last2) % 1024;
      if (v == pred) begin
        if (m_match < 255) m_match++;
        m_locked = 1;
        last2 = last1; last1 = v;
      end else begin
        if (m_err < 255) m_err++;
        m_pulse = 1; m_sticky = 1; m_locked = 0;
        run_len = 1; last1 = v;
      end
    end else begin
      run_len++;
      last2 = last1; last1 = v;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
    chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
    chk({tag, ".match_cnt"}, 32'(match_cnt), 32'(m_match));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
    if (run_len >= 2) chk({tag, ".expected"}, 32'(expected), 32'((last1 + last2) % 1024));
  endtask

  task automatic step(input string tag, input bit v, input int d, input bit c);
    valid = v; din = 10'(d); clr = c;
    @(posedge clk); #1;
    if (c) model_clear();
    else if (v) model_sample(d);
    else m_pulse = 0;
    valid = 1'b0; clr = 1'b0;
    check_all(tag);
  endtask

  task automatic send(input string tag, input int d, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int i = 0; i < g; i++) step({tag, ".gap"}, 1'b0, 0, 1'b0);
    step(tag, 1'b1, d, 1'b0);
  endtask

  task automatic do_reset(input string tag, input bit v);
    nrst = 1'b0; valid = v; din = 10'd3;
    @(posedge clk); #1;
    nrst = 1'b1; valid = 1'b0;
    model_clear();
    check_all(tag);
    chk({tag, ".expected0"}, 32'(expected), 32'd0);
  endtask

  initial begin
    int x, y, z;
    int seq1[7] = '{0, 1, 1, 2, 3, 5, 8};
    int wrap[4] = '{610, 987, 573, 536};
    int mis[7]  = '{0, 1, 1, 2, 4, 7, 11};
    nrst = 1'b0; clr = 1'b0; valid = 1'b0; din = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset", 1'b0);

    foreach (seq1[i]) send("seq", seq1[i], 0);
    chk("seq.match5", 32'(match_cnt), 32'd5);
    chk("seq.locked", 32'(locked), 32'd1);

    step("clr", 1'b0, 0, 1'b1);
    foreach (wrap[i]) send("wrap", wrap[i], 0);
    chk("wrap.match2", 32'(match_cnt), 32'd2);
    chk("wrap.err0", 32'(err_cnt), 32'd0);

    step("clr", 1'b0, 0, 1'b1);
    for (int i = 0; i < 5; i++) send("mis", mis[i], 0);
    chk("mis.err1", 32'(err_cnt), 32'd1);
    chk("mis.pulse", 32'(err_pulse), 32'd1);
    chk("mis.unlocked", 32'(locked), 32'd0);
    step("mis.idle", 1'b0, 0, 1'b0);
    chk("mis.pulse_drop", 32'(err_pulse), 32'd0);
    send("mis", mis[5], 0);
    send("mis", mis[6], 0);
    chk("mis.match3", 32'(match_cnt), 32'd3);
    chk("mis.relock", 32'(locked), 32'd1);
    chk("mis.sticky", 32'(err_sticky), 32'd1);

    step("clr", 1'b0, 0, 1'b1);
    send("gap", 2, 5); send("gap", 3, 5); send("gap", 5, 5); send("gap", 8, 5);
    chk("gap.match2", 32'(match_cnt), 32'd2);
    step("clrv", 1'b1, 8, 1'b1);
    chk("clrv.match0", 32'(match_cnt), 32'd0);
    send("any", 5, 0); send("any", 8, 0); send("any", 13, 0);
    chk("any.match1", 32'(match_cnt), 32'd1);
    chk("any.err0", 32'(err_cnt), 32'd0);

    step("clr", 1'b0, 0, 1'b1);
    x = 0; y = 1;
    send("pre", x, 0); send("pre", y, 0);
    for (int i = 0; i < 9; i++) begin
      z = (x + y) % 1024; x = y; y = z;
      send("pre", z, 2);
    end
    chk("pre.match9", 32'(match_cnt), 32'd9);
    do_reset("midreset", 1'b1);
    send("post", 1, 0); send("post", 2, 0); send("post", 3, 0);
    chk("post.locked", 32'(locked), 32'd1);

    // random runs with random seeds, gaps, injected faults and occasional clears
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(9, 0) == 0) step("rnd.clr", 1'b0, 0, 1'b1);
      x = int'($urandom_range(1023, 0)); y = int'($urandom_range(1023, 0));
      send("rnd", x, 3); send("rnd", y, 3);
      for (int i = 0; i < 8; i++) begin
        z = (x + y) % 1024;
        if ($urandom_range(5, 0) == 0) z = (z + int'($urandom_range(1023, 1))) % 1024;
        x = y; y = z;
        send("rnd", z, 3);
      end
    end

    step("clr", 1'b0, 0, 1'b1);
    x = int'($urandom_range(1023, 0)); y = int'($urandom_range(1023, 0));
    send("satm", x, 0); send("satm", y, 0);
    for (int i = 0; i < 270; i++) begin
      z = (x + y) % 1024; x = y; y = z;
      send("satm", z, 0);
    end
    chk("satm.255", 32'(match_cnt), 32'd255);

    for (int i = 0; i < 900; i++) send("sate", int'($urandom_range(1023, 0)), 0);
    chk("sate.255", 32'(err_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
